// File: rtl/m_merge_stage.sv
// Two-way round-robin merge into a 2-entry ordered buffer with source tagging.
// Acks depend only on registered occupancy, so downstream Ack never reaches upstream Ack.
module m_merge_stage #(
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          MR,
  input  logic          CM_Send_in_a,
  input  logic [DW-1:0] CM_Data_in_a,
  output logic          CM_Ack_out_a,
  input  logic          CM_Send_in_b,
  input  logic [DW-1:0] CM_Data_in_b,
  output logic          CM_Ack_out_b,
  output logic          CM_Send_out,
  output logic [DW-1:0] CM_Data_out,
  output logic          CM_Src_out,
  input  logic          CM_Ack_in,
  output logic          CM_CP
);

  logic [1:0]    count_q, count_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic          rr_q, rr_d;
  logic          cp_q, cp_d;
  logic [DW-1:0] data_q [2];
  logic          src_q  [2];

  logic          can_accept;
  logic          gnt_a, gnt_b;
  logic          push, pop;
  logic          wr_src;
  logic [DW-1:0] wr_data;

  // Arbitration: when both paths send, rr_q picks the side (0 = a).
  always_comb begin
    can_accept = !MR && (count_q != 2'd2);
    gnt_a      = can_accept && CM_Send_in_a && (!CM_Send_in_b || !rr_q);
    gnt_b      = can_accept && CM_Send_in_b && (!CM_Send_in_a ||  rr_q);
    push       = gnt_a || gnt_b;
    pop        = (count_q != 2'd0) && CM_Ack_in;
    wr_src     = gnt_b;
    wr_data    = gnt_b ? CM_Data_in_b : CM_Data_in_a;
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    rr_d    = rr_q;
    cp_d    = 1'b0;
    if (push) begin
      tail_d = ~tail_q;
      rr_d   = ~wr_src;
      cp_d   = 1'b1;
    end
    if (pop) head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      rr_q    <= 1'b0;
      cp_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rr_q    <= rr_d;
      cp_q    <= cp_d;
    end
  end

  // Storage needs no reset: it is only observed while count_q is non-zero.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[tail_q] <= wr_data;
      src_q[tail_q]  <= wr_src;
    end
  end

  assign CM_Ack_out_a = gnt_a;
  assign CM_Ack_out_b = gnt_b;
  assign CM_Send_out  = (count_q != 2'd0);
  assign CM_Data_out  = CM_Send_out ? data_q[head_q] : '0;
  assign CM_Src_out   = CM_Send_out ? src_q[head_q]  : 1'b0;
  assign CM_CP        = cp_q;

endmodule

// File: tb/tb_m_merge_stage.sv
// Directed and randomized checks of the m_merge_stage merge/buffer behaviour.
module tb_m_merge_stage;

  localparam int DW = 16;

  logic          CLK;
  logic          MR;
  logic          CM_Send_in_a, CM_Send_in_b;
  logic [DW-1:0] CM_Data_in_a, CM_Data_in_b;
  logic          CM_Ack_out_a, CM_Ack_out_b;
  logic          CM_Send_out;
  logic [DW-1:0] CM_Data_out;
  logic          CM_Src_out;
  logic          CM_Ack_in;
  logic          CM_CP;

  int n_pass  = 0;
  int n_total = 0;

  m_merge_stage #(.DW(DW)) dut (
    .CLK          (CLK),
    .MR           (MR),
    .CM_Send_in_a (CM_Send_in_a),
    .CM_Data_in_a (CM_Data_in_a),
    .CM_Ack_out_a (CM_Ack_out_a),
    .CM_Send_in_b (CM_Send_in_b),
    .CM_Data_in_b (CM_Data_in_b),
    .CM_Ack_out_b (CM_Ack_out_b),
    .CM_Send_out  (CM_Send_out),
    .CM_Data_out  (CM_Data_out),
    .CM_Src_out   (CM_Src_out),
    .CM_Ack_in    (CM_Ack_in),
    .CM_CP        (CM_CP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    CM_Send_in_a = 1'b0;
    CM_Send_in_b = 1'b0;
    CM_Data_in_a = '0;
    CM_Data_in_b = '0;
    CM_Ack_in    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    MR = 1'b1;
    tick();
    MR = 1'b0;
  endtask

  task automatic test_reset();
    MR = 1'b1;
    CM_Send_in_a = 1'b1; CM_Data_in_a = 16'h5555;
    CM_Send_in_b = 1'b1; CM_Data_in_b = 16'hAAAA;
    CM_Ack_in = 1'b1;
    #1;
    n_total++;
    if (CM_Ack_out_a !== 1'b0 || CM_Ack_out_b !== 1'b0)
      $display("FAIL reset_acks: got a=%b b=%b want 0 0", CM_Ack_out_a, CM_Ack_out_b);
    else n_pass++;
    tick();
    n_total++;
    if (CM_Send_out !== 1'b0 || CM_Data_out !== 16'h0 || CM_Src_out !== 1'b0 || CM_CP !== 1'b0)
      $display("FAIL reset_outputs: got send=%b data=%h src=%b cp=%b want 0 0000 0 0",
               CM_Send_out, CM_Data_out, CM_Src_out, CM_CP);
    else n_pass++;
    MR = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    CM_Send_in_a = 1'b1; CM_Data_in_a = 16'h1234; CM_Ack_in = 1'b1;
    #1;
    n_total++;
    if (CM_Ack_out_a !== 1'b1 || CM_Ack_out_b !== 1'b0)
      $display("FAIL single_ack: got a=%b b=%b want 1 0", CM_Ack_out_a, CM_Ack_out_b);
    else n_pass++;
    tick();
    CM_Send_in_a = 1'b0;
    #1;
    n_total++;
    if (CM_Send_out !== 1'b1 || CM_Data_out !== 16'h1234 || CM_Src_out !== 1'b0 || CM_CP !== 1'b1)
      $display("FAIL single_out: got send=%b data=%h src=%b cp=%b want 1 1234 0 1",
               CM_Send_out, CM_Data_out, CM_Src_out, CM_CP);
    else n_pass++;
    tick();
    n_total++;
    if (CM_Send_out !== 1'b0 || CM_Data_out !== 16'h0 || CM_CP !== 1'b0)
      $display("FAIL single_drain: got send=%b data=%h cp=%b want 0 0000 0",
               CM_Send_out, CM_Data_out, CM_CP);
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [15:0] exp_data [6];
    logic        exp_src  [6];
    int ia, ib;
    exp_data[0] = 16'h00A0; exp_src[0] = 1'b0;
    exp_data[1] = 16'h00B0; exp_src[1] = 1'b1;
    exp_data[2] = 16'h00A1; exp_src[2] = 1'b0;
    exp_data[3] = 16'h00B1; exp_src[3] = 1'b1;
    exp_data[4] = 16'h00A2; exp_src[4] = 1'b0;
    exp_data[5] = 16'h00B2; exp_src[5] = 1'b1;
    ia = 0; ib = 0;
    do_reset();
    CM_Ack_in = 1'b1;
    for (int c = 0; c < 7; c++) begin
      CM_Send_in_a = 1'b1; CM_Data_in_a = 16'h00A0 + 16'(ia);
      CM_Send_in_b = 1'b1; CM_Data_in_b = 16'h00B0 + 16'(ib);
      #1;
      n_total++;
      if (CM_Ack_out_a !== ((c % 2) == 0) || CM_Ack_out_b !== ((c % 2) == 1))
        $display("FAIL alt_grant c=%0d: got a=%b b=%b want a=%b", c, CM_Ack_out_a, CM_Ack_out_b,
                 (c % 2) == 0);
      else n_pass++;
      if (c >= 1) begin
        n_total++;
        if (CM_Send_out !== 1'b1 || CM_Data_out !== exp_data[c-1] || CM_Src_out !== exp_src[c-1])
          $display("FAIL alt_out c=%0d: got send=%b data=%h src=%b want 1 %h %b", c,
                   CM_Send_out, CM_Data_out, CM_Src_out, exp_data[c-1], exp_src[c-1]);
        else n_pass++;
      end
      if ((c % 2) == 0) ia++; else ib++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    CM_Ack_in = 1'b0;
    CM_Send_in_b = 1'b1; CM_Data_in_b = 16'h0C01;
    #1;
    n_total++;
    if (CM_Ack_out_b !== 1'b1) $display("FAIL stall_ack1: got %b want 1", CM_Ack_out_b);
    else n_pass++;
    tick();
    CM_Data_in_b = 16'h0C02;
    #1;
    n_total++;
    if (CM_Ack_out_b !== 1'b1) $display("FAIL stall_ack2: got %b want 1", CM_Ack_out_b);
    else n_pass++;
    tick();
    CM_Data_in_b = 16'h0C03;
    #1;
    n_total++;
    if (CM_Ack_out_b !== 1'b0) $display("FAIL stall_ack3_full: got %b want 0", CM_Ack_out_b);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (CM_Ack_out_b !== 1'b0 || CM_Send_out !== 1'b1 || CM_Data_out !== 16'h0C01 || CM_Src_out !== 1'b1)
      $display("FAIL stall_hold: got ack=%b send=%b data=%h src=%b want 0 1 0c01 1",
               CM_Ack_out_b, CM_Send_out, CM_Data_out, CM_Src_out);
    else n_pass++;
    CM_Ack_in = 1'b1;
    #1;
    n_total++;
    if (CM_Ack_out_b !== 1'b0) $display("FAIL stall_pop_noack: got %b want 0", CM_Ack_out_b);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (CM_Ack_out_b !== 1'b1 || CM_Data_out !== 16'h0C02)
      $display("FAIL stall_release2: got ack=%b data=%h want 1 0c02", CM_Ack_out_b, CM_Data_out);
    else n_pass++;
    tick();
    CM_Send_in_b = 1'b0;
    #1;
    n_total++;
    if (CM_Send_out !== 1'b1 || CM_Data_out !== 16'h0C03 || CM_Src_out !== 1'b1)
      $display("FAIL stall_release3: got send=%b data=%h src=%b want 1 0c03 1",
               CM_Send_out, CM_Data_out, CM_Src_out);
    else n_pass++;
    tick();
    n_total++;
    if (CM_Send_out !== 1'b0) $display("FAIL stall_empty: got %b want 0", CM_Send_out);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_full_pop();
    do_reset();
    CM_Send_in_a = 1'b1; CM_Data_in_a = 16'h0D01;
    tick();
    CM_Data_in_a = 16'h0D02;
    tick();
    CM_Data_in_a = 16'h0D03; CM_Ack_in = 1'b1;
    #1;
    n_total++;
    if (CM_Ack_out_a !== 1'b0 || CM_Data_out !== 16'h0D01)
      $display("FAIL full_pop_noacc: got ack=%b data=%h want 0 0d01", CM_Ack_out_a, CM_Data_out);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (CM_Ack_out_a !== 1'b1 || CM_Data_out !== 16'h0D02 || CM_CP !== 1'b0)
      $display("FAIL full_pop_next: got ack=%b data=%h cp=%b want 1 0d02 0",
               CM_Ack_out_a, CM_Data_out, CM_CP);
    else n_pass++;
    tick();
    CM_Send_in_a = 1'b0;
    #1;
    n_total++;
    if (CM_Data_out !== 16'h0D03 || CM_CP !== 1'b1)
      $display("FAIL full_pop_last: got data=%h cp=%b want 0d03 1", CM_Data_out, CM_CP);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    CM_Send_in_b = 1'b1; CM_Data_in_b = 16'h0E01;
    tick();
    CM_Send_in_a = 1'b1; CM_Data_in_a = 16'h0E02;
    CM_Data_in_b = 16'h0E03;
    tick();
    MR = 1'b1;
    #1;
    n_total++;
    if (CM_Ack_out_a !== 1'b0 || CM_Ack_out_b !== 1'b0 || CM_Send_out !== 1'b1)
      $display("FAIL mid_reset_cycle: got a=%b b=%b send=%b want 0 0 1",
               CM_Ack_out_a, CM_Ack_out_b, CM_Send_out);
    else n_pass++;
    tick();
    MR = 1'b0;
    #1;
    n_total++;
    if (CM_Send_out !== 1'b0 || CM_Data_out !== 16'h0 || CM_Src_out !== 1'b0 || CM_CP !== 1'b0)
      $display("FAIL mid_reset_out: got send=%b data=%h src=%b cp=%b want 0 0000 0 0",
               CM_Send_out, CM_Data_out, CM_Src_out, CM_CP);
    else n_pass++;
    n_total++;
    if (CM_Ack_out_a !== 1'b1 || CM_Ack_out_b !== 1'b0)
      $display("FAIL mid_reset_first_grant: got a=%b b=%b want 1 0", CM_Ack_out_a, CM_Ack_out_b);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [16:0] q[$];
    logic        rr, prev_acc, ga, gb, pop;
    logic [16:0] head;
    int na, nb, n_acc, n_cp;
    do_reset();
    rr = 1'b0; prev_acc = 1'b0;
    na = 0; nb = 0; n_acc = 0; n_cp = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!CM_Send_in_a && $urandom_range(0, 2) != 0) begin
        CM_Send_in_a = 1'b1; CM_Data_in_a = 16'(na); na++;
      end
      if (!CM_Send_in_b && $urandom_range(0, 2) != 0) begin
        CM_Send_in_b = 1'b1; CM_Data_in_b = 16'h8000 | 16'(nb); nb++;
      end
      CM_Ack_in = ($urandom_range(0, 3) != 0);
      #1;
      ga = (q.size() != 2) && CM_Send_in_a && (!CM_Send_in_b || !rr);
      gb = (q.size() != 2) && CM_Send_in_b && (!CM_Send_in_a || rr);
      head = (q.size() != 0) ? q[0] : 17'h0;
      n_total++;
      if (CM_Ack_out_a !== ga || CM_Ack_out_b !== gb)
        $display("FAIL rand_grant c=%0d: got a=%b b=%b want a=%b b=%b", c,
                 CM_Ack_out_a, CM_Ack_out_b, ga, gb);
      else n_pass++;
      n_total++;
      if (CM_Send_out !== (q.size() != 0) || {CM_Src_out, CM_Data_out} !== head)
        $display("FAIL rand_out c=%0d: got send=%b src=%b data=%h want %b %b %h", c,
                 CM_Send_out, CM_Src_out, CM_Data_out, q.size() != 0, head[16], head[15:0]);
      else n_pass++;
      n_total++;
      if (CM_CP !== prev_acc)
        $display("FAIL rand_cp c=%0d: got %b want %b", c, CM_CP, prev_acc);
      else n_pass++;
      if (CM_CP === 1'b1) n_cp++;
      pop = (q.size() != 0) && CM_Ack_in;
      if (pop) void'(q.pop_front());
      if (ga) begin q.push_back({1'b0, CM_Data_in_a}); rr = 1'b1; end
      if (gb) begin q.push_back({1'b1, CM_Data_in_b}); rr = 1'b0; end
      prev_acc = ga || gb;
      if (ga || gb) n_acc++;
      tick();
      if (ga) CM_Send_in_a = 1'b0;
      if (gb) CM_Send_in_b = 1'b0;
    end
    #1;
    if (CM_CP === 1'b1) n_cp++;
    n_total++;
    if (n_cp !== n_acc) $display("FAIL rand_cp_count: got %0d want %0d", n_cp, n_acc);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    MR = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
